alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer for a strobe-loaded ALU: loads A/B/D operands, waits for FINP,
// reads back result and flags, and returns them through a valid/ready response port.
module alu_sequencer #(
    parameter int unsigned HOLD    = 2,
    parameter int unsigned SETTLE  = 1,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [15:0] cmd_d,
    output logic [15:0] A,
    output logic [5:0]  op,
    output logic        WA,
    output logic        WB,
    output logic        WD,
    output logic [1:0]  WR,
    input  logic [15:0] R1,
    input  logic        FINP,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [15:0] rsp_flags,
    output logic        rsp_timeout
);

    localparam logic [7:0] HOLD_LAST    = 8'(HOLD - 1);
    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StLoadA, StLoadB, StLoadD, StWait, StReadR, StReadF, StResp
    } state_e;

    state_e      r_state;
    state_e      w_next_state;
    logic [7:0]  r_cnt;
    logic [5:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_d;
    logic        w_accept;
    logic        w_hold_done;
    logic        w_settle_done;
    logic        w_timeout;

    assign w_accept      = cmd_ready && cmd_valid;
    assign w_hold_done   = (r_cnt == HOLD_LAST);
    assign w_settle_done = (r_cnt == SETTLE_LAST);
    // FINP wins if it arrives on the very last allowed WAIT cycle.
    assign w_timeout     = (r_state == StWait) && !FINP && (r_cnt == TIMEOUT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_next_state = StLoadA;
            StLoadA: if (w_hold_done) w_next_state = StLoadB;
            StLoadB: if (w_hold_done) w_next_state = StLoadD;
            StLoadD: if (w_hold_done) w_next_state = StWait;
            StWait: begin
                if (FINP) begin
                    w_next_state = StReadR;
                end else if (w_timeout) begin
                    w_next_state = StResp;
                end
            end
            StReadR: if (w_settle_done) w_next_state = StReadF;
            StReadF: if (w_settle_done) w_next_state = StResp;
            StResp:  if (rsp_ready) w_next_state = StIdle;
            default: w_next_state = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        A         = 16'd0;
        op        = 6'd0;
        WA        = 1'b0;
        WB        = 1'b0;
        WD        = 1'b0;
        WR        = 2'd0;
        rsp_valid = 1'b0;
        unique case (r_state)
            StIdle:  cmd_ready = !RST;
            StLoadA: begin
                A  = r_a;
                op = r_op;
                WA = 1'b1;
            end
            StLoadB: begin
                A  = r_b;
                op = r_op;
                WB = 1'b1;
            end
            StLoadD: begin
                A  = r_d;
                op = r_op;
                WD = 1'b1;
            end
            StWait:  op = r_op;
            StReadR: op = r_op;
            StReadF: begin
                op = r_op;
                WR = 2'd3;
            end
            StResp:  rsp_valid = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Counter restarts on every state change; idle states keep it parked at zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= 8'd0;
        end else if ((w_next_state != r_state) || (r_state == StIdle) || (r_state == StResp)) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op        <= 6'd0;
            r_a         <= 16'd0;
            r_b         <= 16'd0;
            r_d         <= 16'd0;
            rsp_result  <= 16'd0;
            rsp_flags   <= 16'd0;
            rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op        <= cmd_op;
                r_a         <= cmd_a;
                r_b         <= cmd_b;
                r_d         <= cmd_d;
                rsp_timeout <= 1'b0;
            end
            if (w_timeout) begin
                rsp_result  <= 16'd0;
                rsp_flags   <= 16'd0;
                rsp_timeout <= 1'b1;
            end
            if ((r_state == StReadR) && w_settle_done) begin
                rsp_result <= R1;
            end
            if ((r_state == StReadF) && w_settle_done) begin
                rsp_flags <= R1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: default-parameter instance plus a HOLD=1/SETTLE=3 instance,
// with hand-derived per-cycle expectations.
module tb_alu_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_valid2 = 1'b0;
    logic [5:0]  cmd_op = 6'd0;
    logic [15:0] cmd_a = 16'd0;
    logic [15:0] cmd_b = 16'd0;
    logic [15:0] cmd_d = 16'd0;
    logic        FINP = 1'b0;
    logic        FINP2 = 1'b0;
    logic        rsp_ready = 1'b1;
    logic [15:0] alu_result = 16'd0;
    logic [15:0] alu_flags = 16'd0;
    logic [15:0] R1;
    logic [15:0] R1_2 = 16'd0;

    logic        cmd_ready, WA, WB, WD, rsp_valid, rsp_timeout;
    logic [15:0] A, rsp_result, rsp_flags;
    logic [5:0]  op;
    logic [1:0]  WR;
    logic        cmd_ready2, WA2, WB2, WD2, rsp_valid2, rsp_timeout2;
    logic [15:0] A2, rsp_result2, rsp_flags2;
    logic [5:0]  op2;
    logic [1:0]  WR2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    // Model ALU read port: flags on WR=3, result otherwise.
    assign R1 = (WR == 2'd3) ? alu_flags : alu_result;

    alu_sequencer dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d),
        .A(A), .op(op), .WA(WA), .WB(WB), .WD(WD), .WR(WR), .R1(R1), .FINP(FINP),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout)
    );

    alu_sequencer #(.HOLD(1), .SETTLE(3), .TIMEOUT(20)) dut2 (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d),
        .A(A2), .op(op2), .WA(WA2), .WB(WB2), .WD(WD2), .WR(WR2), .R1(R1_2), .FINP(FINP2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
        .rsp_flags(rsp_flags2), .rsp_timeout(rsp_timeout2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  exp_str;
        logic [15:0] exp_a;
        int          first_valid;
        logic        wr3_seen;
        logic        valid_seen;

        // Reset state
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_A", A, 0);
        check("rst_op", op, 0);
        check("rst_WR", WR, 0);
        check("rst_strobes", {WA, WB, WD}, 0);
        check("rst_result", rsp_result, 0);
        check("rst_cmd_ready2", cmd_ready2, 0);
        repeat (3) tick();
        RST = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Nominal command, FINP on second WAIT cycle
        alu_result = 16'hFFD0;
        alu_flags  = 16'h0005;
        cmd_op = 6'd5; cmd_a = 16'd52493; cmd_b = 16'd52541; cmd_d = 16'd10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            exp_str = (i <= 2) ? 3'b100 : (i <= 4) ? 3'b010 : (i <= 6) ? 3'b001 : 3'b000;
            exp_a   = (i <= 2) ? 16'd52493 : (i <= 4) ? 16'd52541 : (i <= 6) ? 16'd10 : 16'd0;
            check($sformatf("t1_strobes_c%0d", i), {WA, WB, WD}, exp_str);
            check($sformatf("t1_A_c%0d", i), A, exp_a);
            check($sformatf("t1_op_c%0d", i), op, (i <= 10) ? 5 : 0);
            check($sformatf("t1_WR_c%0d", i), WR, (i == 10) ? 3 : 0);
            check($sformatf("t1_valid_c%0d", i), rsp_valid, (i == 11) ? 1 : 0);
            if (i == 11) begin
                check("t1_result", rsp_result, 16'hFFD0);
                check("t1_flags", rsp_flags, 16'h0005);
                check("t1_timeout", rsp_timeout, 0);
            end
            if (i == 12) check("t1_idle_ready", cmd_ready, 1);
            FINP = (i == 8);
            tick();
        end

        // Timeout: FINP never asserted, then back-pressure on the response
        rsp_ready = 1'b0;
        alu_result = 16'hBEEF;
        cmd_op = 6'd9; cmd_a = 16'd1; cmd_b = 16'd2; cmd_d = 16'd3;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        first_valid = -1;
        wr3_seen = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            if (WR == 2'd3) wr3_seen = 1'b1;
            if (rsp_valid) begin
                first_valid = i;
                break;
            end
            tick();
        end
        check("t2_first_valid_cycle", first_valid, 207);
        check("t2_timeout", rsp_timeout, 1);
        check("t2_result", rsp_result, 0);
        check("t2_flags", rsp_flags, 0);
        check("t2_wr3_seen", wr3_seen, 0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_valid_k%0d", k), rsp_valid, 1);
            check($sformatf("t3_result_k%0d", k), rsp_result, 0);
            check($sformatf("t3_timeout_k%0d", k), rsp_timeout, 1);
            check($sformatf("t3_cmd_ready_k%0d", k), cmd_ready, 0);
            cmd_valid = ((k % 2) == 0);
            tick();
        end
        check("t3_valid_after_hold", rsp_valid, 1);

        // Back-to-back command with cmd_valid held and FINP held high
        alu_result = 16'h1234;
        alu_flags  = 16'h00A5;
        cmd_op = 6'd12; cmd_a = 16'hA5A5; cmd_b = 16'h5A5A; cmd_d = 16'h0F0F;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        FINP = 1'b1;
        tick();
        check("t4_idle_ready", cmd_ready, 1);
        check("t4_idle_valid", rsp_valid, 0);
        check("t4_timeout_kept", rsp_timeout, 1);
        tick();
        check("t4_timeout_cleared", rsp_timeout, 0);
        check("t4_WA", WA, 1);
        check("t4_A", A, 16'hA5A5);
        check("t4_op", op, 12);
        first_valid = -1;
        for (int j = 1; j <= 30; j++) begin
            if (rsp_valid) begin
                first_valid = j;
                break;
            end
            tick();
        end
        check("t4_first_valid_cycle", first_valid, 10);
        check("t4_result", rsp_result, 16'h1234);
        check("t4_flags", rsp_flags, 16'h00A5);
        check("t4_timeout", rsp_timeout, 0);
        cmd_valid = 1'b0;
        FINP = 1'b0;
        tick();
        check("t4_done_valid", rsp_valid, 0);
        check("t4_done_ready", cmd_ready, 1);

        // Asynchronous reset in the middle of LOAD_B
        cmd_op = 6'd7; cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_d = 16'h3333;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("t5_pre_WB", WB, 1);
        check("t5_pre_A", A, 16'h2222);
        #2;
        RST = 1'b1;
        #1;
        check("t5_WB", WB, 0);
        check("t5_A", A, 0);
        check("t5_op", op, 0);
        check("t5_cmd_ready", cmd_ready, 0);
        check("t5_result", rsp_result, 0);
        check("t5_flags", rsp_flags, 0);
        check("t5_valid", rsp_valid, 0);
        tick();
        tick();
        RST = 1'b0;
        #1;
        check("t5_post_ready", cmd_ready, 1);
        FINP = 1'b1;
        valid_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid || !cmd_ready) valid_seen = 1'b1;
            tick();
        end
        FINP = 1'b0;
        check("t5_no_response", valid_seen, 0);

        // HOLD=1, SETTLE=3 instance, R1 changes every read cycle
        rsp_ready = 1'b1;
        cmd_op = 6'd3; cmd_a = 16'h00AA; cmd_b = 16'h00BB; cmd_d = 16'h00CC;
        cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            exp_str = (i == 1) ? 3'b100 : (i == 2) ? 3'b010 : (i == 3) ? 3'b001 : 3'b000;
            exp_a   = (i == 1) ? 16'h00AA : (i == 2) ? 16'h00BB : (i == 3) ? 16'h00CC : 16'd0;
            check($sformatf("t6_strobes_c%0d", i), {WA2, WB2, WD2}, exp_str);
            check($sformatf("t6_A_c%0d", i), A2, exp_a);
            check($sformatf("t6_op_c%0d", i), op2, (i <= 10) ? 3 : 0);
            check($sformatf("t6_WR_c%0d", i), WR2, (i >= 8 && i <= 10) ? 3 : 0);
            check($sformatf("t6_valid_c%0d", i), rsp_valid2, (i == 11) ? 1 : 0);
            if (i == 11) begin
                check("t6_result", rsp_result2, 16'h3333);
                check("t6_flags", rsp_flags2, 16'h6666);
                check("t6_timeout", rsp_timeout2, 0);
            end
            FINP2 = (i == 4);
            R1_2  = (i >= 5 && i <= 10) ? 16'(32'h1111 * (i - 4)) : 16'h0000;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
